// File: rtl/lc3_decode_pkg.sv
// lc3_decode_pkg: shared opcode, control-field encodings and control word types for the decode stage
package lc3_decode_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RSV  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCS1_NONE = 2'b00;
    localparam logic [1:0] PCS1_OFF9 = 2'b01;
    localparam logic [1:0] PCS1_OFF6 = 2'b10;
    localparam logic [1:0] PCS1_ZERO = 2'b11;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_MEM = 2'b01;
    localparam logic [1:0] W_PC  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// lc3_decode_ctrl: combinational opcode lookup producing execute/writeback/memory controls
module lc3_decode_ctrl
    import lc3_decode_pkg::*;
(
    input  logic [WORD_W-1:0] instr,
    output e_ctrl_t           e_ctrl,
    output logic [1:0]        w_ctrl,
    output logic              mem_ctrl,
    output logic              illegal
);

    opcode_e op;
    e_ctrl_t pc_rel;

    assign op     = opcode_e'(instr[15:12]);
    assign pc_rel = '{alu_control: ALU_ADD, pcselect1: PCS1_OFF9, pcselect2: 1'b1, op2select: 1'b0};

    // Decode the opcode; unsupported opcodes leave every control field at zero
    always_comb begin
        e_ctrl   = '0;
        w_ctrl   = W_ALU;
        mem_ctrl = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_ADD: e_ctrl = '{alu_control: ALU_ADD, pcselect1: PCS1_NONE, pcselect2: 1'b0, op2select: ~instr[5]};
            OP_AND: e_ctrl = '{alu_control: ALU_AND, pcselect1: PCS1_NONE, pcselect2: 1'b0, op2select: ~instr[5]};
            OP_NOT: e_ctrl = '{alu_control: ALU_NOT, pcselect1: PCS1_NONE, pcselect2: 1'b0, op2select: 1'b0};
            OP_BR:  e_ctrl = pc_rel;
            OP_JMP: e_ctrl = '{alu_control: ALU_ADD, pcselect1: PCS1_ZERO, pcselect2: 1'b0, op2select: 1'b0};
            OP_LD: begin
                e_ctrl = pc_rel;
                w_ctrl = W_MEM;
            end
            OP_LDR: begin
                e_ctrl = '{alu_control: ALU_ADD, pcselect1: PCS1_OFF6, pcselect2: 1'b0, op2select: 1'b0};
                w_ctrl = W_MEM;
            end
            OP_LDI: begin
                e_ctrl   = pc_rel;
                w_ctrl   = W_MEM;
                mem_ctrl = 1'b1;
            end
            OP_LEA: begin
                e_ctrl = pc_rel;
                w_ctrl = W_PC;
            end
            OP_ST:  e_ctrl = pc_rel;
            OP_STR: e_ctrl = '{alu_control: ALU_ADD, pcselect1: PCS1_OFF6, pcselect2: 1'b0, op2select: 1'b0};
            OP_STI: begin
                e_ctrl   = pc_rel;
                mem_ctrl = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lc3_decode.sv
// lc3_decode: decode pipeline stage latching the instruction, next PC and its decoded controls
module lc3_decode
    import lc3_decode_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [WORD_W-1:0] dout,
    input  logic [WORD_W-1:0] npc_in,
    output logic [WORD_W-1:0] IR,
    output logic [WORD_W-1:0] npc_out,
    output logic [5:0]        E_Control,
    output logic [1:0]        W_Control,
    output logic              Mem_Control,
    output logic              illegal
);

    e_ctrl_t    e_next;
    logic [1:0] w_next;
    logic       mem_next;
    logic       ill_next;

    lc3_decode_ctrl u_ctrl (
        .instr    (dout),
        .e_ctrl   (e_next),
        .w_ctrl   (w_next),
        .mem_ctrl (mem_next),
        .illegal  (ill_next)
    );

    // Capture instruction and its freshly decoded controls when enabled, hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IR          <= '0;
            npc_out     <= '0;
            E_Control   <= '0;
            W_Control   <= '0;
            Mem_Control <= 1'b0;
            illegal     <= 1'b0;
        end else if (enable_decode) begin
            IR          <= dout;
            npc_out     <= npc_in;
            E_Control   <= e_next;
            W_Control   <= w_next;
            Mem_Control <= mem_next;
            illegal     <= ill_next;
        end
    end

endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: directed self-checking bench for the decode stage
module tb_lc3_decode;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [41:0] obs;
    assign obs = {IR, npc_out, E_Control, W_Control, Mem_Control, illegal};

    lc3_decode dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_Control     (E_Control),
        .W_Control     (W_Control),
        .Mem_Control   (Mem_Control),
        .illegal       (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_power_on();
        #3;
        checks++;
        if (obs !== 42'd0) begin
            errors++;
            $display("FAIL power_on: got %h expected %h", obs, 42'd0);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_add_reg();
        enable_decode = 1'b1;
        dout   = 16'h1283;
        npc_in = 16'h3001;
        step();
        checks++;
        if (obs !== {16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_reg: got %h expected %h", obs, {16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        enable_decode = 1'b1;
        dout   = 16'h12A5;
        npc_in = 16'h3002;
        step();
        checks++;
        if (obs !== {16'h12A5, 16'h3002, 6'b000000, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_add_imm: got %h expected %h", obs, {16'h12A5, 16'h3002, 6'b000000, 2'b00, 1'b0, 1'b0});
        end
        dout   = 16'hA405;
        npc_in = 16'h3003;
        step();
        checks++;
        if (obs !== {16'hA405, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_ldi: got %h expected %h", obs, {16'hA405, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b0});
        end
    endtask

    task automatic test_stall();
        enable_decode = 1'b1;
        dout   = 16'hC1C0;
        npc_in = 16'h3004;
        step();
        checks++;
        if (obs !== {16'hC1C0, 16'h3004, 6'b001100, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_load_jmp: got %h expected %h", obs, {16'hC1C0, 16'h3004, 6'b001100, 2'b00, 1'b0, 1'b0});
        end
        enable_decode = 1'b0;
        dout   = 16'h5000;
        npc_in = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {16'hC1C0, 16'h3004, 6'b001100, 2'b00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, {16'hC1C0, 16'h3004, 6'b001100, 2'b00, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_illegal();
        enable_decode = 1'b1;
        dout   = 16'hF025;
        npc_in = 16'h3010;
        step();
        checks++;
        if (obs !== {16'hF025, 16'h3010, 6'b000000, 2'b00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_trap: got %h expected %h", obs, {16'hF025, 16'h3010, 6'b000000, 2'b00, 1'b0, 1'b1});
        end
        dout   = 16'hE1FF;
        npc_in = 16'h3011;
        step();
        checks++;
        if (obs !== {16'hE1FF, 16'h3011, 6'b000110, 2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL illegal_then_lea: got %h expected %h", obs, {16'hE1FF, 16'h3011, 6'b000110, 2'b10, 1'b0, 1'b0});
        end
    endtask

    task automatic test_all_opcodes();
        logic [9:0] ctrl_tab [16];
        ctrl_tab[0]  = {6'b000110, 2'b00, 1'b0, 1'b0};
        ctrl_tab[1]  = {6'b000001, 2'b00, 1'b0, 1'b0};
        ctrl_tab[2]  = {6'b000110, 2'b01, 1'b0, 1'b0};
        ctrl_tab[3]  = {6'b000110, 2'b00, 1'b0, 1'b0};
        ctrl_tab[4]  = {6'b000000, 2'b00, 1'b0, 1'b1};
        ctrl_tab[5]  = {6'b010001, 2'b00, 1'b0, 1'b0};
        ctrl_tab[6]  = {6'b001000, 2'b01, 1'b0, 1'b0};
        ctrl_tab[7]  = {6'b001000, 2'b00, 1'b0, 1'b0};
        ctrl_tab[8]  = {6'b000000, 2'b00, 1'b0, 1'b1};
        ctrl_tab[9]  = {6'b100000, 2'b00, 1'b0, 1'b0};
        ctrl_tab[10] = {6'b000110, 2'b01, 1'b1, 1'b0};
        ctrl_tab[11] = {6'b000110, 2'b00, 1'b1, 1'b0};
        ctrl_tab[12] = {6'b001100, 2'b00, 1'b0, 1'b0};
        ctrl_tab[13] = {6'b000000, 2'b00, 1'b0, 1'b1};
        ctrl_tab[14] = {6'b000110, 2'b10, 1'b0, 1'b0};
        ctrl_tab[15] = {6'b000000, 2'b00, 1'b0, 1'b1};
        enable_decode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dout   = {i[3:0], 12'h000};
            npc_in = 16'h4000 + 16'(i);
            step();
            checks++;
            if (obs !== {dout, npc_in, ctrl_tab[i]}) begin
                errors++;
                $display("FAIL opcode_%0h: got %h expected %h", i, obs, {dout, npc_in, ctrl_tab[i]});
            end
        end
    endtask

    task automatic test_reset();
        enable_decode = 1'b1;
        dout   = 16'hA405;
        npc_in = 16'h5555;
        step();
        checks++;
        if (obs !== {16'hA405, 16'h5555, 6'b000110, 2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_preload: got %h expected %h", obs, {16'hA405, 16'h5555, 6'b000110, 2'b01, 1'b1, 1'b0});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 42'd0) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", obs, 42'd0);
        end
        step();
        checks++;
        if (obs !== 42'd0) begin
            errors++;
            $display("FAIL reset_wins_over_enable: got %h expected %h", obs, 42'd0);
        end
        reset = 1'b1;
        enable_decode = 1'b0;
        step();
        checks++;
        if (obs !== 42'd0) begin
            errors++;
            $display("FAIL reset_release_hold: got %h expected %h", obs, 42'd0);
        end
        enable_decode = 1'b1;
        dout   = 16'h9FFF;
        npc_in = 16'h0001;
        step();
        checks++;
        if (obs !== {16'h9FFF, 16'h0001, 6'b100000, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_capture: got %h expected %h", obs, {16'h9FFF, 16'h0001, 6'b100000, 2'b00, 1'b0, 1'b0});
        end
    endtask

    initial begin
        reset         = 1'b0;
        enable_decode = 1'b0;
        dout          = 16'h0;
        npc_in        = 16'h0;
        test_power_on();
        test_add_reg();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_all_opcodes();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
